// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared core constants: data/instruction widths, the default
//               reset PC and the instruction-alignment helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  typedef logic [XLEN-1:0] addr_t;
  typedef logic [ILEN-1:0] instr_t;

  localparam addr_t RESET_PC_DEFAULT = 32'h0000_0000;
  localparam addr_t INSTR_ALIGN_MASK = 32'hFFFF_FFFC;

  // Force a PC onto a word boundary; the low two bits carry no meaning.
  function automatic addr_t align_pc(input addr_t pc);
    return pc & INSTR_ALIGN_MASK;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Parametrised synchronous FIFO holding prefetched instruction
//               words. Pointers carry an extra wrap bit so that full/empty and
//               the occupancy count fall out of a single subtraction.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [AW:0] C_FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      occupancy;

  // Occupancy and status flags derived from the wrap-bit pointers.
  always_comb begin
    occupancy = wr_ptr_q - rd_ptr_q;
    count     = CW'(occupancy);
    full      = (occupancy == C_FULL_CNT);
    empty     = (occupancy == '0);
    rdata     = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer advance; a flush wins over any same-cycle push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are meaningless until pointed at, so no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch front end. Issues sequential word requests
//               on a req/gnt/rvalid bus, buffers responses in a prefetch FIFO
//               and hands them to decode. A redirect flushes the buffer and
//               marks every in-flight response for discard.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import core_pkg::*;
#(
  parameter addr_t       RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [ILEN-1:0]  imem_rdata,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [ILEN-1:0]  instr_data,
  output logic [XLEN-1:0]  instr_pc,
  output logic             busy
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] C_ISSUE_CAP = (CW + 1)'(FIFO_DEPTH);

  addr_t          fetch_pc_q, fetch_pc_d;
  addr_t          head_pc_q, head_pc_d;
  logic [CW-1:0]  outst_q, outst_d;
  logic [CW-1:0]  discard_q, discard_d;

  logic [CW-1:0]  fifo_count;
  logic           fifo_full, fifo_empty;
  logic           fifo_push, fifo_pop;
  logic [CW:0]    inflight_sum;
  logic           gnt_fire;
  logic           rsp_drop;
  addr_t          target_pc;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ILEN)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (imem_rdata),
    .pop   (fifo_pop),
    .flush (redirect_valid),
    .rdata (instr_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Issue gating and handshake decode. Buffered plus in-flight words never
  // exceed the FIFO depth, which is what makes a push into a full FIFO
  // impossible. Reset gates the request so the bus sees nothing until release.
  always_comb begin
    inflight_sum = {1'b0, fifo_count} + {1'b0, outst_q};
    imem_req     = rst_n && !redirect_valid && (inflight_sum < C_ISSUE_CAP);
    imem_addr    = fetch_pc_q;
    gnt_fire     = imem_req && imem_gnt;
    rsp_drop     = (discard_q != '0);
    fifo_push    = imem_rvalid && !rsp_drop && !redirect_valid;
    fifo_pop     = !fifo_empty && instr_ready && !redirect_valid;
    target_pc    = align_pc(redirect_pc);
    instr_valid  = !fifo_empty;
    instr_pc     = head_pc_q;
    busy         = (outst_q != '0) || !fifo_empty;
  end

  // Next-state for PCs and counters. On redirect every response still owed by
  // the bus (after this cycle's arrival, if any) becomes a discard.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_pc_d  = head_pc_q;
    outst_d    = outst_q + CW'(gnt_fire) - CW'(imem_rvalid);
    discard_d  = discard_q;
    if (redirect_valid) begin
      fetch_pc_d = target_pc;
      head_pc_d  = target_pc;
      discard_d  = outst_q - CW'(imem_rvalid);
    end else begin
      if (gnt_fire)                fetch_pc_d = fetch_pc_q + 32'd4;
      if (fifo_pop)                head_pc_d  = head_pc_q + 32'd4;
      if (imem_rvalid && rsp_drop) discard_d  = discard_q - {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // PC and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      head_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  // A response with nothing outstanding is a bus protocol violation.
  a_rvalid_has_outstanding : assert property (
    @(posedge clk) disable iff (!rst_n) imem_rvalid |-> (outst_q != '0));

  // The issue limit must keep the buffer from ever overflowing.
  a_no_push_when_full : assert property (
    @(posedge clk) disable iff (!rst_n) fifo_push |-> !fifo_full);

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit. Instance A uses
//               default parameters, instance B uses RESET_PC=0x8000_0000.
//               A small latency-programmable memory model answers each one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // stimulus driven by the test tasks
  logic [1:0]        m_rst_n = 2'b11;
  logic [1:0]        m_rdy   = 2'b00;
  logic [1:0]        gnt_en  = 2'b00;
  int                lat [2] = '{1, 1};
  logic              redir_a = 1'b0;
  logic [31:0]       redir_pc_a = 32'h0;
  logic              redir_b = 1'b0;
  logic [31:0]       redir_pc_b = 32'h0;

  // memory-model driven DUT inputs
  logic [1:0]        m_gnt    = 2'b00;
  logic [1:0]        m_rvalid = 2'b00;
  logic [1:0][31:0]  m_rdata  = '0;

  // DUT outputs
  logic        a_req, a_valid, a_busy, b_req, b_valid, b_busy;
  logic [31:0] a_addr, a_data, a_pc, b_addr, b_data, b_pc;
  logic [1:0]        m_req;
  logic [1:0][31:0]  m_addr;
  assign m_req  = {b_req, a_req};
  assign m_addr = {b_addr, a_addr};

  fetch_unit dut_a (
    .clk(clk), .rst_n(m_rst_n[0]),
    .redirect_valid(redir_a), .redirect_pc(redir_pc_a),
    .imem_req(a_req), .imem_addr(a_addr), .imem_gnt(m_gnt[0]),
    .imem_rvalid(m_rvalid[0]), .imem_rdata(m_rdata[0]),
    .instr_valid(a_valid), .instr_ready(m_rdy[0]),
    .instr_data(a_data), .instr_pc(a_pc), .busy(a_busy)
  );

  fetch_unit #(.RESET_PC(32'h8000_0000), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(m_rst_n[1]),
    .redirect_valid(redir_b), .redirect_pc(redir_pc_b),
    .imem_req(b_req), .imem_addr(b_addr), .imem_gnt(m_gnt[1]),
    .imem_rvalid(m_rvalid[1]), .imem_rdata(m_rdata[1]),
    .instr_valid(b_valid), .instr_ready(m_rdy[1]),
    .instr_data(b_data), .instr_pc(b_pc), .busy(b_busy)
  );

  // In-order memory model: instruction word at address X is ~X; each grant
  // is answered lat[k] cycles later. Acts on the falling edge.
  logic [31:0] pa [2][16];
  int          pd [2][16];
  int          ph [2] = '{0, 0};
  int          pt [2] = '{0, 0};
  int          cyc = 0;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!m_rst_n[k]) begin
        ph[k] = 0; pt[k] = 0;
        m_rvalid[k] = 1'b0;
        m_gnt[k] = 1'b0;
      end else begin
        m_gnt[k] = gnt_en[k];
        m_rvalid[k] = 1'b0;
        if (ph[k] != pt[k] && pd[k][ph[k] % 16] <= cyc) begin
          m_rvalid[k] = 1'b1;
          m_rdata[k]  = ~pa[k][ph[k] % 16];
          ph[k]++;
        end
        if (m_req[k] && m_gnt[k]) begin
          pa[k][pt[k] % 16] = m_addr[k];
          pd[k][pt[k] % 16] = cyc + lat[k];
          pt[k]++;
        end
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Quiesce instance A, then redirect it to pc with an empty pipeline.
  task automatic restart(input logic [31:0] pc);
    int n;
    gnt_en[0] = 1'b0;
    m_rdy[0]  = 1'b1;
    tick();
    tick();
    n = 0;
    while (a_busy && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (a_busy !== 1'b0) begin
      failures++;
      $display("FAIL restart_drain: busy=%0b after %0d cycles, expected 0", a_busy, n);
    end
    redir_a = 1'b1;
    redir_pc_a = pc;
    tick();
    redir_a = 1'b0;
  endtask

  task automatic test_reset();
    m_rst_n = 2'b00;
    repeat (3) tick();
    checks++;
    if (a_req !== 1'b0 || a_valid !== 1'b0 || a_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_a_ctl: req=%0b valid=%0b busy=%0b, expected 0/0/0", a_req, a_valid, a_busy);
    end
    checks++;
    if (a_addr !== 32'h0 || a_pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_a_pc: addr=%h pc=%h, expected 0/0", a_addr, a_pc);
    end
    checks++;
    if (b_req !== 1'b0 || b_valid !== 1'b0 || b_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_b_ctl: req=%0b valid=%0b busy=%0b, expected 0/0/0", b_req, b_valid, b_busy);
    end
    checks++;
    if (b_addr !== 32'h8000_0000 || b_pc !== 32'h8000_0000) begin
      failures++;
      $display("FAIL reset_b_pc: addr=%h pc=%h, expected 80000000", b_addr, b_pc);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp_pc;
    tick();
    m_rst_n[0] = 1'b1; m_rdy[0] = 1'b1; gnt_en[0] = 1'b1; lat[0] = 1;
    #1;
    checks++;
    if (a_req !== 1'b1 || a_addr !== 32'h0) begin
      failures++;
      $display("FAIL zw_first_req: req=%0b addr=%h, expected 1/0", a_req, a_addr);
    end
    tick();
    checks++;
    if (a_addr !== 32'h4 || a_valid !== 1'b0) begin
      failures++;
      $display("FAIL zw_cycle1: addr=%h valid=%0b, expected 4/0", a_addr, a_valid);
    end
    for (int k = 2; k < 8; k++) begin
      tick();
      exp_pc = 32'(k - 2) * 32'd4;
      checks++;
      if (a_valid !== 1'b1 || a_pc !== exp_pc || a_data !== ~exp_pc || a_addr !== 32'(k * 4)) begin
        failures++;
        $display("FAIL zw_stream[%0d]: valid=%0b pc=%h data=%h addr=%h, expected 1/%h/%h/%h",
                 k, a_valid, a_pc, a_data, a_addr, exp_pc, ~exp_pc, 32'(k * 4));
      end
    end
  endtask

  task automatic test_stall();
    logic exp_req, exp_val;
    logic [31:0] exp_pc;
    restart(32'h0);
    gnt_en[0] = 1'b1; lat[0] = 1; m_rdy[0] = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      exp_req = (i < 4);
      exp_val = (i >= 2);
      checks++;
      if (a_req !== exp_req || a_valid !== exp_val ||
          (exp_val && (a_pc !== 32'h0 || a_data !== 32'hFFFF_FFFF))) begin
        failures++;
        $display("FAIL stall[%0d]: req=%0b valid=%0b pc=%h data=%h, expected %0b/%0b/0/ffffffff",
                 i, a_req, a_valid, a_pc, a_data, exp_req, exp_val);
      end
      if (i < 9) tick();
    end
    checks++;
    if (a_busy !== 1'b1) begin
      failures++;
      $display("FAIL stall_busy: busy=%0b, expected 1", a_busy);
    end
    tick();
    m_rdy[0] = 1'b1;
    #1;
    for (int j = 0; j < 4; j++) begin
      exp_pc = 32'(j) * 32'd4;
      checks++;
      if (a_valid !== 1'b1 || a_pc !== exp_pc || a_data !== ~exp_pc) begin
        failures++;
        $display("FAIL stall_release[%0d]: valid=%0b pc=%h data=%h, expected 1/%h/%h",
                 j, a_valid, a_pc, a_data, exp_pc, ~exp_pc);
      end
      tick();
    end
  endtask

  task automatic test_redirect_latency();
    restart(32'h0);
    gnt_en[0] = 1'b1; lat[0] = 4; m_rdy[0] = 1'b1;
    repeat (3) tick();
    redir_a = 1'b1; redir_pc_a = 32'h0000_0103;
    #1;
    checks++;
    if (a_req !== 1'b0) begin
      failures++;
      $display("FAIL redir_no_req: req=%0b, expected 0", a_req);
    end
    tick();
    redir_a = 1'b0;
    #1;
    checks++;
    if (a_req !== 1'b1 || a_addr !== 32'h100 || a_busy !== 1'b1) begin
      failures++;
      $display("FAIL redir_target: req=%0b addr=%h busy=%0b, expected 1/100/1", a_req, a_addr, a_busy);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (a_valid !== 1'b0) begin
        failures++;
        $display("FAIL redir_stale[%0d]: valid=%0b pc=%h data=%h, expected valid 0", k, a_valid, a_pc, a_data);
      end
      tick();
    end
    checks++;
    if (a_valid !== 1'b1 || a_pc !== 32'h100 || a_data !== ~32'h100) begin
      failures++;
      $display("FAIL redir_first: valid=%0b pc=%h data=%h, expected 1/100/%h", a_valid, a_pc, a_data, ~32'h100);
    end
    tick();
    checks++;
    if (a_valid !== 1'b1 || a_pc !== 32'h104 || a_data !== ~32'h104) begin
      failures++;
      $display("FAIL redir_second: valid=%0b pc=%h data=%h, expected 1/104/%h", a_valid, a_pc, a_data, ~32'h104);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    restart(32'h0);
    gnt_en[0] = 1'b1; lat[0] = 3; m_rdy[0] = 1'b1;
    repeat (3) tick();
    redir_a = 1'b1; redir_pc_a = 32'h300;
    tick();
    redir_pc_a = 32'h200;
    gnt_en[0] = 1'b0;
    #1;
    checks++;
    if (a_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_valid_t1: valid=%0b pc=%h, expected 0", a_valid, a_pc);
    end
    tick();
    redir_a = 1'b0;
    #1;
    checks++;
    if (a_req !== 1'b1 || a_addr !== 32'h200 || a_busy !== 1'b1 || a_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_pending: req=%0b addr=%h busy=%0b valid=%0b, expected 1/200/1/0",
               a_req, a_addr, a_busy, a_valid);
    end
    tick();
    checks++;
    if (a_busy !== 1'b0 || a_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: busy=%0b valid=%0b, expected 0/0", a_busy, a_valid);
    end
    gnt_en[0] = 1'b1;
    n = 0;
    while (a_valid !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    checks++;
    if (a_valid !== 1'b1 || a_pc !== 32'h200 || a_data !== ~32'h200) begin
      failures++;
      $display("FAIL b2b_first: valid=%0b pc=%h data=%h after %0d cycles, expected 1/200/%h",
               a_valid, a_pc, a_data, n, ~32'h200);
    end
  endtask

  task automatic test_gnt_stall();
    restart(32'h40);
    lat[0] = 1; m_rdy[0] = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (a_req !== 1'b1 || a_addr !== 32'h40) begin
        failures++;
        $display("FAIL gnt_hold[%0d]: req=%0b addr=%h, expected 1/40", i, a_req, a_addr);
      end
      if (i < 4) tick();
    end
    gnt_en[0] = 1'b1;
    tick();
    checks++;
    if (a_addr !== 32'h44) begin
      failures++;
      $display("FAIL gnt_advance: addr=%h, expected 44", a_addr);
    end
    tick();
    checks++;
    if (a_valid !== 1'b1 || a_pc !== 32'h40 || a_data !== ~32'h40 || a_addr !== 32'h48) begin
      failures++;
      $display("FAIL gnt_resume: valid=%0b pc=%h data=%h addr=%h, expected 1/40/%h/48",
               a_valid, a_pc, a_data, a_addr, ~32'h40);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    tick();
    m_rst_n[1] = 1'b1; gnt_en[1] = 1'b1; lat[1] = 3; m_rdy[1] = 1'b1;
    #1;
    checks++;
    if (b_req !== 1'b1 || b_addr !== 32'h8000_0000) begin
      failures++;
      $display("FAIL rp_first_req: req=%0b addr=%h, expected 1/80000000", b_req, b_addr);
    end
    tick();
    checks++;
    if (b_addr !== 32'h8000_0004) begin
      failures++;
      $display("FAIL rp_advance: addr=%h, expected 80000004", b_addr);
    end
    tick();
    m_rst_n[1] = 1'b0;
    #1;
    checks++;
    if (b_req !== 1'b0 || b_valid !== 1'b0 || b_busy !== 1'b0 ||
        b_addr !== 32'h8000_0000 || b_pc !== 32'h8000_0000) begin
      failures++;
      $display("FAIL rp_async_reset: req=%0b valid=%0b busy=%0b addr=%h pc=%h, expected 0/0/0/80000000/80000000",
               b_req, b_valid, b_busy, b_addr, b_pc);
    end
    tick();
    m_rst_n[1] = 1'b1;
    #1;
    checks++;
    if (b_req !== 1'b1 || b_addr !== 32'h8000_0000) begin
      failures++;
      $display("FAIL rp_restart: req=%0b addr=%h, expected 1/80000000", b_req, b_addr);
    end
    n = 0;
    while (b_valid !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    checks++;
    if (b_valid !== 1'b1 || b_pc !== 32'h8000_0000 || b_data !== ~32'h8000_0000) begin
      failures++;
      $display("FAIL rp_first_instr: valid=%0b pc=%h data=%h after %0d cycles, expected 1/80000000/%h",
               b_valid, b_pc, b_data, n, ~32'h8000_0000);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_zero_wait();
    test_stall();
    test_redirect_latency();
    test_back_to_back();
    test_gnt_stall();
    test_reset_mid();
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
